// File: rtl/ma_stage.sv
// Memory-access stage: launches load/store requests on a req/ack data-memory port,
// stalls upstream while an access is outstanding, and registers the MA/RW payload.
package ma_pkg;
  typedef struct packed {
    logic       isLd;
    logic       isSt;
    logic       rfWe;
    logic [1:0] wbSel;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } Ex_Ma_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] ldresult;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } Ma_Rw_t;
endpackage

module ma_stage
  import ma_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  Ex_Ma_t      Ex_Payld,
  input  logic        Ex_Valid,
  output logic        Ma_Stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output Ma_Rw_t      Ma_Payld,
  output logic        Ma_Valid,
  output logic        Ma_Err
);

  localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 9) ? $clog2(ACK_TIMEOUT + 1) : 9;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  Ma_Rw_t             payld_q, payld_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic is_mem_op;
  logic mem;
  logic in_wait;
  logic timeout_hit;
  logic acked;
  logic update;

  assign is_mem_op = Ex_Payld.ctrl.isLd | Ex_Payld.ctrl.isSt;
  assign mem       = Ex_Valid & is_mem_op;
  assign in_wait   = (state_q == S_WAIT);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // The wait that brings the count up to ACK_TIMEOUT is the last one allowed.
  assign timeout_hit = in_wait & ~dmem_ack & (cnt_inc == CNT_W'(ACK_TIMEOUT));

  // Gate with Rst so a pending launch cannot appear on the port while reset is held.
  assign dmem_req   = Rst & ((~in_wait & Start & mem) | in_wait);
  assign dmem_we    = Ex_Payld.ctrl.isSt;
  assign dmem_addr  = Ex_Payld.aluresult;
  assign dmem_wdata = Ex_Payld.op2;

  assign acked    = dmem_req & dmem_ack;
  assign Ma_Stall = dmem_req & ~dmem_ack & ~timeout_hit;
  assign update   = Start | (in_wait & dmem_ack);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    payld_d = payld_q;
    valid_d = 1'b0;
    err_d   = timeout_hit;
    if (update && Ex_Valid && (!is_mem_op || acked)) begin
      payld_d.pc        = Ex_Payld.pc;
      payld_d.aluresult = Ex_Payld.aluresult;
      payld_d.instr     = Ex_Payld.instr;
      payld_d.ctrl      = Ex_Payld.ctrl;
      payld_d.ldresult  = (is_mem_op && Ex_Payld.ctrl.isLd) ? dmem_rdata : 32'd0;
      valid_d           = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      payld_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      payld_q <= payld_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Ma_Payld = payld_q;
  assign Ma_Valid = valid_q;
  assign Ma_Err   = err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: expected MA/RW payloads are queued when an
// instruction is driven and compared whenever Ma_Valid rises.
module tb_ma_stage;
  import ma_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Start;
  Ex_Ma_t      ex;
  logic        Ex_Valid;
  logic        Ma_Stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        ack;
  logic [31:0] rdata;
  Ma_Rw_t      Ma_Payld;
  logic        Ma_Valid;
  logic        Ma_Err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  Ma_Rw_t sb[$];

  ma_stage #(.ACK_TIMEOUT(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Ex_Payld   (ex),
    .Ex_Valid   (Ex_Valid),
    .Ma_Stall   (Ma_Stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (ack),
    .dmem_rdata (rdata),
    .Ma_Payld   (Ma_Payld),
    .Ma_Valid   (Ma_Valid),
    .Ma_Err     (Ma_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL #%0d %s: observed 0x%08h expected 0x%08h", n_fail, tag, obs, exp);
    end
  endtask

  function automatic Ex_Ma_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                input logic [31:0] op2, input logic [31:0] instr,
                                input logic ld, input logic st);
    Ex_Ma_t p;
    p.pc         = pc;
    p.aluresult  = alu;
    p.op2        = op2;
    p.instr      = instr;
    p.ctrl.isLd  = ld;
    p.ctrl.isSt  = st;
    p.ctrl.rfWe  = ~st;
    p.ctrl.wbSel = ld ? 2'd1 : 2'd0;
    return p;
  endfunction

  task automatic push(input Ex_Ma_t p, input logic [31:0] ldres);
    Ma_Rw_t e;
    e.pc        = p.pc;
    e.aluresult = p.aluresult;
    e.ldresult  = ldres;
    e.instr     = p.instr;
    e.ctrl      = p.ctrl;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample 1 time unit after the edge, retire any output.
  task automatic tick();
    Ma_Rw_t e;
    @(posedge Clk);
    #1;
    if (Ma_Valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(Ma_Valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pc",     Ma_Payld.pc,        e.pc);
        check("sb_alu",    Ma_Payld.aluresult, e.aluresult);
        check("sb_ldres",  Ma_Payld.ldresult,  e.ldresult);
        check("sb_instr",  Ma_Payld.instr,     e.instr);
        check("sb_ctrl",   32'(Ma_Payld.ctrl), 32'(e.ctrl));
      end
    end
  endtask

  initial begin
    Ex_Ma_t p;

    // Reset, with a launchable load presented to prove the port stays quiet.
    Rst      = 1'b0;
    Start    = 1'b1;
    Ex_Valid = 1'b1;
    ex       = mk(32'h0, 32'h80, 32'h0, 32'h00002083, 1'b1, 1'b0);
    ack      = 1'b0;
    rdata    = 32'h0;
    #3;
    check("rst_req",    32'(dmem_req), 32'd0);
    check("rst_stall",  32'(Ma_Stall), 32'd0);
    check("rst_valid",  32'(Ma_Valid), 32'd0);
    check("rst_err",    32'(Ma_Err),   32'd0);
    check("rst_alu",    Ma_Payld.aluresult, 32'd0);
    check("rst_pc",     Ma_Payld.pc,        32'd0);
    Ex_Valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    // ALU pass-through.
    p = mk(32'h1000, 32'h10, 32'h0, 32'h00208033, 1'b0, 1'b0);
    ex = p; Ex_Valid = 1'b1;
    #1;
    check("alu_stall", 32'(Ma_Stall), 32'd0);
    check("alu_req",   32'(dmem_req), 32'd0);
    push(p, 32'd0);
    tick();
    check("alu_valid", 32'(Ma_Valid), 32'd1);

    // Back-to-back zero-wait loads, then an ALU op: no bubbles.
    p = mk(32'h1004, 32'h100, 32'h0, 32'h00002083, 1'b1, 1'b0);
    ex = p; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    check("ld0_req",   32'(dmem_req), 32'd1);
    check("ld0_addr",  dmem_addr,     32'h100);
    check("ld0_we",    32'(dmem_we),  32'd0);
    check("ld0_stall", 32'(Ma_Stall), 32'd0);
    push(p, 32'hDEAD_BEEF);
    tick();
    check("ld0_valid", 32'(Ma_Valid), 32'd1);
    p = mk(32'h1008, 32'h104, 32'h0, 32'h00402103, 1'b1, 1'b0);
    ex = p; rdata = 32'h1122_3344;
    #1;
    check("ld1_stall", 32'(Ma_Stall), 32'd0);
    push(p, 32'h1122_3344);
    tick();
    check("ld1_valid", 32'(Ma_Valid), 32'd1);
    p = mk(32'h100C, 32'h77, 32'h0, 32'h00308033, 1'b0, 1'b0);
    ex = p; ack = 1'b0;
    push(p, 32'd0);
    tick();
    check("alu2_valid", 32'(Ma_Valid), 32'd1);

    // Store acked three cycles after launch.
    p = mk(32'h1010, 32'h200, 32'h1234_5678, 32'h0020A023, 1'b0, 1'b1);
    ex = p;
    push(p, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_stall", 32'(Ma_Stall), 32'd1);
      check("st_req",   32'(dmem_req), 32'd1);
      check("st_we",    32'(dmem_we),  32'd1);
      check("st_addr",  dmem_addr,     32'h200);
      check("st_wdata", dmem_wdata,    32'h1234_5678);
      tick();
      check("st_wait_valid", 32'(Ma_Valid), 32'd0);
    end
    ack = 1'b1;
    #1;
    check("st_ack_stall", 32'(Ma_Stall), 32'd0);
    check("st_ack_req",   32'(dmem_req), 32'd1);
    tick();
    check("st_valid", 32'(Ma_Valid), 32'd1);
    ack = 1'b0; Ex_Valid = 1'b0;
    tick();
    check("st_valid_one_cycle", 32'(Ma_Valid), 32'd0);

    // A stray ack with no request is ignored.
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    check("stray_req", 32'(dmem_req), 32'd0);
    tick();
    check("stray_valid", 32'(Ma_Valid), 32'd0);
    ack = 1'b0;

    // Load never acked: ACK_TIMEOUT=4 gives five request cycles.
    ex = mk(32'h1014, 32'h300, 32'h0, 32'h00002083, 1'b1, 1'b0);
    Ex_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_req",   32'(dmem_req), 32'd1);
      check("to_stall", 32'(Ma_Stall), (i < 4) ? 32'd1 : 32'd0);
      tick();
      check("to_err",   32'(Ma_Err),   (i == 4) ? 32'd1 : 32'd0);
      check("to_valid", 32'(Ma_Valid), 32'd0);
    end
    p = mk(32'h1018, 32'h55, 32'h0, 32'h00508033, 1'b0, 1'b0);
    ex = p;
    push(p, 32'd0);
    #1;
    check("to_next_req", 32'(dmem_req), 32'd0);
    tick();
    check("to_err_pulse", 32'(Ma_Err),   32'd0);
    check("to_next_valid", 32'(Ma_Valid), 32'd1);

    // Start dropped during WAIT: the access still completes.
    p = mk(32'h101C, 32'h400, 32'h0, 32'h00002083, 1'b1, 1'b0);
    ex = p;
    #1;
    check("sd_launch", 32'(dmem_req), 32'd1);
    tick();
    Start = 1'b0;
    #1;
    check("sd_hold_req",   32'(dmem_req), 32'd1);
    check("sd_hold_stall", 32'(Ma_Stall), 32'd1);
    tick();
    check("sd_wait_valid", 32'(Ma_Valid), 32'd0);
    ack = 1'b1; rdata = 32'h0000_00A5;
    push(p, 32'h0000_00A5);
    #1;
    check("sd_ack_stall", 32'(Ma_Stall), 32'd0);
    tick();
    check("sd_valid", 32'(Ma_Valid), 32'd1);
    check("sd_ldres", Ma_Payld.ldresult, 32'h0000_00A5);
    ack = 1'b0;
    ex = mk(32'h1020, 32'h500, 32'h0, 32'h00002083, 1'b1, 1'b0);
    #1;
    check("sd_no_launch", 32'(dmem_req), 32'd0);
    check("sd_no_stall",  32'(Ma_Stall), 32'd0);
    tick();
    check("sd_idle_valid", 32'(Ma_Valid), 32'd0);
    ex = mk(32'h1024, 32'h999, 32'h0, 32'h00608033, 1'b0, 1'b0);
    tick();
    check("sd_alu_valid", 32'(Ma_Valid), 32'd0);
    check("sd_hold_alu",  Ma_Payld.aluresult, 32'h400);
    Start = 1'b1; Ex_Valid = 1'b0;
    tick();

    // Reset asserted mid-WAIT; a late ack afterwards produces nothing.
    ex = mk(32'h1028, 32'h600, 32'h0, 32'h00002083, 1'b1, 1'b0);
    Ex_Valid = 1'b1;
    #1;
    check("rw_launch", 32'(dmem_req), 32'd1);
    tick();
    tick();
    Rst = 1'b0;
    #1;
    check("rw_req",   32'(dmem_req), 32'd0);
    check("rw_stall", 32'(Ma_Stall), 32'd0);
    check("rw_valid", 32'(Ma_Valid), 32'd0);
    check("rw_alu",   Ma_Payld.aluresult, 32'd0);
    Ex_Valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    tick();
    ack = 1'b1; rdata = 32'h0000_0BAD;
    #1;
    check("rw_late_req", 32'(dmem_req), 32'd0);
    tick();
    check("rw_late_valid", 32'(Ma_Valid), 32'd0);
    ack = 1'b0;
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
